// File: rtl/sd_access_arbiter_if.sv
// Bundle between the SD access arbiter, its two sector-level requesters,
// the init/read/write engines and the card pins.
//
// Handshake: a requester raises reqN (with rwN/secN valid) and holds it
// until doneN; the arbiter samples rwN/secN on the grant edge, holds gntN
// high from grant until the doneN pulse, and pulses errN together with doneN
// when the transaction was aborted. Engines get a one-cycle wr_req/rd_req and
// answer with a wr_done/rd_done level that rises on completion.
interface sd_access_arbiter_if;
    logic        init_done;
    logic        req0;
    logic        rw0;
    logic [31:0] sec0;
    logic        gnt0;
    logic        done0;
    logic        err0;
    logic        req1;
    logic        rw1;
    logic [31:0] sec1;
    logic        gnt1;
    logic        done1;
    logic        err1;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] eng_sec;
    logic        wr_done;
    logic        rd_done;
    logic        init_cs;
    logic        init_din;
    logic        wr_cs;
    logic        wr_din;
    logic        rd_cs;
    logic        rd_din;
    logic        SD_cs;
    logic        SD_datain;
    logic [2:0]  state_dbg;

    // Arbiter side
    modport slave (
        input  init_done, req0, rw0, sec0, req1, rw1, sec1,
        input  wr_done, rd_done, init_cs, init_din, wr_cs, wr_din, rd_cs, rd_din,
        output gnt0, done0, err0, gnt1, done1, err1,
        output wr_req, rd_req, eng_sec, SD_cs, SD_datain, state_dbg
    );

    // Requester / engine / card side
    modport master (
        output init_done, req0, rw0, sec0, req1, rw1, sec1,
        output wr_done, rd_done, init_cs, init_din, wr_cs, wr_din, rd_cs, rd_din,
        input  gnt0, done0, err0, gnt1, done1, err1,
        input  wr_req, rd_req, eng_sec, SD_cs, SD_datain, state_dbg
    );
endinterface

// File: rtl/sd_access_arbiter.sv
// SD access arbiter: shares the SPI-mode SD card between requester 0 (CPU
// bridge) and requester 1 (capture path). Waits for card init, grants
// round-robin, starts the read/write engine for one sector, and muxes the
// card pins from whichever engine owns the bus.
// Optional feature macro: SD_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts
// a transaction after TIMEOUT_CYC cycles with an error pulse.
module sd_access_arbiter #(
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TO_W        = 22
) (
    input  logic                   SD_clk,
    input  logic                   rst,
    sd_access_arbiter_if.slave     bus
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_BUSY      = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t            state;
    logic              rr_ptr;
    logic              who;
    logic              op;
    logic [1:0]        gnt_r;
    logic [1:0]        done_r;
    logic [1:0]        err_r;
    logic              wr_req_r;
    logic              rd_req_r;
    logic [31:0]       sec_r;
    logic              done_prev;
    logic [GAP_W-1:0]  gap_cnt;
`ifdef SD_ARB_TIMEOUT_EN
    logic [TO_W-1:0]   to_cnt;
`endif

    logic              pick;
    logic              eng_done;
    logic              done_edge;

    // Requester selection and completion edge of the engine in use
    always_comb begin
        pick      = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
        eng_done  = op ? bus.wr_done : bus.rd_done;
        done_edge = eng_done && !done_prev;
    end

    // Arbitration FSM with registered grant/done/error/engine-request outputs
    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) begin
            state     <= S_WAIT_INIT;
            rr_ptr    <= 1'b0;
            who       <= 1'b0;
            op        <= 1'b0;
            gnt_r     <= 2'b00;
            done_r    <= 2'b00;
            err_r     <= 2'b00;
            wr_req_r  <= 1'b0;
            rd_req_r  <= 1'b0;
            sec_r     <= 32'd0;
            done_prev <= 1'b0;
            gap_cnt   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
            done_r   <= 2'b00;
            err_r    <= 2'b00;
            if (state != S_WAIT_INIT && !bus.init_done) begin
                // Card lost: abort whatever is in flight and re-wait for init
                gnt_r <= 2'b00;
                if (state == S_ISSUE || state == S_BUSY) begin
                    done_r[who] <= 1'b1;
                    err_r[who]  <= 1'b1;
                end
                state <= S_WAIT_INIT;
            end else begin
                case (state)
                    S_WAIT_INIT: begin
                        if (bus.init_done) state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (bus.req0 || bus.req1) begin
                            who   <= pick;
                            gnt_r <= pick ? 2'b10 : 2'b01;
                            op    <= pick ? bus.rw1 : bus.rw0;
                            sec_r <= pick ? bus.sec1 : bus.sec0;
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        wr_req_r  <= op;
                        rd_req_r  <= !op;
                        // Seed edge history with the current level so a done
                        // still held from the previous transaction is not
                        // mistaken for this one's completion
                        done_prev <= eng_done;
`ifdef SD_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                        state     <= S_BUSY;
                    end
                    S_BUSY: begin
                        done_prev <= eng_done;
                        if (done_edge) begin
                            done_r[who] <= 1'b1;
                            gnt_r       <= 2'b00;
                            rr_ptr      <= !who;
                            gap_cnt     <= '0;
                            state       <= S_GAP;
                        end
`ifdef SD_ARB_TIMEOUT_EN
                        else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            done_r[who] <= 1'b1;
                            err_r[who]  <= 1'b1;
                            gnt_r       <= 2'b00;
                            rr_ptr      <= !who;
                            gap_cnt     <= '0;
                            state       <= S_GAP;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= S_IDLE;
                        else gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: state <= S_WAIT_INIT;
                endcase
            end
        end
    end

    // Card pin mux: init engine while waiting, active engine while busy,
    // otherwise deselected with MOSI high
    always_comb begin
        bus.SD_cs     = 1'b1;
        bus.SD_datain = 1'b1;
        case (state)
            S_WAIT_INIT: begin
                bus.SD_cs     = bus.init_cs;
                bus.SD_datain = bus.init_din;
            end
            S_BUSY: begin
                bus.SD_cs     = op ? bus.wr_cs  : bus.rd_cs;
                bus.SD_datain = op ? bus.wr_din : bus.rd_din;
            end
            default: ;
        endcase
    end

    assign bus.gnt0      = gnt_r[0];
    assign bus.gnt1      = gnt_r[1];
    assign bus.done0     = done_r[0];
    assign bus.done1     = done_r[1];
    assign bus.err0      = err_r[0];
    assign bus.err1      = err_r[1];
    assign bus.wr_req    = wr_req_r;
    assign bus.rd_req    = rd_req_r;
    assign bus.eng_sec   = sec_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed bench for sd_access_arbiter: init hold-off, read and write
// transactions, round-robin alternation with gap timing, init loss in BUSY,
// and asynchronous reset in BUSY.
module tb_sd_access_arbiter;

    localparam int GAP_CYC = 8;
    localparam logic [1:0] PIN_IDLE = 2'b11;
    localparam logic [1:0] PIN_INIT = 2'b10;
    localparam logic [1:0] PIN_WR   = 2'b00;
    localparam logic [1:0] PIN_RD   = 2'b01;
    localparam logic [2:0] ST_WAIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_access_arbiter_if bus();

    sd_access_arbiter #(
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (2000000),
        .TO_W        (22)
    ) dut (
        .SD_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Scoreboard
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pins();
        return {bus.SD_cs, bus.SD_datain};
    endfunction

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.gnt0 || bus.gnt1) && cyc < 200);
        check("gnt_seen", {31'd0, bus.gnt0 | bus.gnt1}, 32'd1);
    endtask

    // One complete transaction for requester 'who'; caller has set req/rw/sec
    task automatic do_txn(input int who, input bit rw, input logic [31:0] sec,
                          input bit drop_req, input int busy, output int gcyc);
        wait_gnt(gcyc);
        check("gnt_who", {30'd0, bus.gnt1, bus.gnt0}, (who == 1) ? 32'd2 : 32'd1);
        check("eng_sec", bus.eng_sec, sec);
        check("issue_state", {29'd0, bus.state_dbg}, {29'd0, ST_ISSUE});
        check("issue_pins", {30'd0, pins()}, {30'd0, PIN_IDLE});
        check("issue_no_req", {30'd0, bus.wr_req, bus.rd_req}, 32'd0);
        tick(1);
        check("eng_req", {30'd0, bus.wr_req, bus.rd_req}, rw ? 32'd2 : 32'd1);
        check("busy_state", {29'd0, bus.state_dbg}, {29'd0, ST_BUSY});
        check("busy_pins", {30'd0, pins()}, {30'd0, rw ? PIN_WR : PIN_RD});
        if (rw) bus.wr_done = 1'b0;
        else    bus.rd_done = 1'b0;
        if (drop_req) begin
            if (who == 1) bus.req1 = 1'b0;
            else          bus.req0 = 1'b0;
        end
        tick(1);
        check("req_one_cycle", {30'd0, bus.wr_req, bus.rd_req}, 32'd0);
        check("gnt_held", {30'd0, bus.gnt1, bus.gnt0}, (who == 1) ? 32'd2 : 32'd1);
        tick(busy);
        if (rw) bus.wr_done = 1'b1;
        else    bus.rd_done = 1'b1;
        tick(1);
        check("done_pulse", {30'd0, bus.done1, bus.done0}, (who == 1) ? 32'd2 : 32'd1);
        check("err_clear", {30'd0, bus.err1, bus.err0}, 32'd0);
        check("gnt_drop", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("gap_state", {29'd0, bus.state_dbg}, {29'd0, ST_GAP});
        tick(1);
        check("done_one_cycle", {30'd0, bus.done1, bus.done0}, 32'd0);
    endtask

    // Stimulus
    initial begin
        int g;
        int who;
        bus.init_done = 1'b0;
        bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.sec0 = 32'd0;
        bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.sec1 = 32'd0;
        bus.wr_done = 1'b0; bus.rd_done = 1'b0;
        bus.init_cs = 1'b1; bus.init_din = 1'b0;
        bus.wr_cs   = 1'b0; bus.wr_din   = 1'b0;
        bus.rd_cs   = 1'b0; bus.rd_din   = 1'b1;
        rst = 1'b1;
        tick(2);
        check("rst_state", {29'd0, bus.state_dbg}, {29'd0, ST_WAIT});
        check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("rst_done_err", {28'd0, bus.done1, bus.done0, bus.err1, bus.err0}, 32'd0);
        check("rst_eng_req", {30'd0, bus.wr_req, bus.rd_req}, 32'd0);
        check("rst_eng_sec", bus.eng_sec, 32'd0);
        check("rst_pins", {30'd0, pins()}, {30'd0, PIN_INIT});

        // Request before init completes is held off
        rst = 1'b0;
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.sec0 = 32'h0000_0055;
        tick(3);
        check("hold_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("hold_state", {29'd0, bus.state_dbg}, {29'd0, ST_WAIT});
        check("hold_pins", {30'd0, pins()}, {30'd0, PIN_INIT});
        bus.init_done = 1'b1;
        tick(1);
        check("init_idle", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
        check("init_no_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        do_txn(0, 1'b0, 32'h0000_0055, 1'b1, 2, g);
        check("first_gnt_latency", g, 32'd1);

        // Write from requester 0 after the gap
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.sec0 = 32'h0000_1000;
        do_txn(0, 1'b1, 32'h0000_1000, 1'b1, 4, g);
        check("solo_regrant_gap", g, GAP_CYC);

        // Both requesting: rr_ptr points at 1 after requester 0 completed
        bus.rw0 = 1'b0; bus.sec0 = 32'h0000_0A00;
        bus.rw1 = 1'b1; bus.sec1 = 32'h0000_0B00;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            who = int'(exp_q.pop_front());
            do_txn(who, (who == 1), (who == 1) ? 32'h0000_0B00 : 32'h0000_0A00, 1'b0, 3, g);
            check("alt_gap", g, GAP_CYC);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Init lost while BUSY aborts with error
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.sec0 = 32'h0000_2000;
        wait_gnt(g);
        check("abort_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        tick(1);
        bus.wr_done = 1'b0;
        tick(1);
        check("abort_busy", {29'd0, bus.state_dbg}, {29'd0, ST_BUSY});
        bus.init_done = 1'b0;
        tick(1);
        check("abort_err", {30'd0, bus.err1, bus.err0}, 32'd1);
        check("abort_done", {30'd0, bus.done1, bus.done0}, 32'd1);
        check("abort_gnt_drop", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("abort_state", {29'd0, bus.state_dbg}, {29'd0, ST_WAIT});
        check("abort_pins", {30'd0, pins()}, {30'd0, PIN_INIT});
        bus.req0 = 1'b0;
        tick(1);
        check("abort_one_cycle", {28'd0, bus.done1, bus.done0, bus.err1, bus.err0}, 32'd0);

        // Asynchronous reset in BUSY
        bus.init_done = 1'b1;
        bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.sec1 = 32'h0000_3000;
        wait_gnt(g);
        check("rstbusy_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        tick(2);
        check("rstbusy_busy", {29'd0, bus.state_dbg}, {29'd0, ST_BUSY});
        #2 rst = 1'b1;
        #1;
        check("async_state", {29'd0, bus.state_dbg}, {29'd0, ST_WAIT});
        check("async_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("async_eng_sec", bus.eng_sec, 32'd0);
        check("async_pins", {30'd0, pins()}, {30'd0, PIN_INIT});
        bus.req1 = 1'b0;
        bus.rd_done = 1'b0;
        tick(1);
        rst = 1'b0;
        bus.rd_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("no_done_after_rst", {28'd0, bus.done1, bus.done0, bus.err1, bus.err0}, 32'd0);
        end

        // rr_ptr back to 0 after reset: simultaneous requests grant 0 first
        bus.rw0 = 1'b0; bus.sec0 = 32'h0000_0040;
        bus.rw1 = 1'b1; bus.sec1 = 32'h0000_0041;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        do_txn(0, 1'b0, 32'h0000_0040, 1'b1, 2, g);
        bus.req1 = 1'b0;
        tick(2);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

endmodule
